// File: rtl/ref_bank_pkg.sv
// Shared sizes, index types, FSM encodings and address helper for the reference-pixel bank scheduler.
package ref_bank_pkg;

    localparam int PIXEL    = 8;
    localparam int WORD_W   = 8 * PIXEL;
    localparam int SEG_LEN  = 24;
    localparam int NUM_SEG  = 4;
    localparam int NUM_BANK = 4;
    localparam int ADDR_W   = 7;
    localparam int SEG_W    = $clog2(NUM_SEG);
    localparam int BANK_W   = $clog2(NUM_BANK);
    localparam int ROW_W    = 5;

    typedef logic [SEG_W-1:0]  seg_idx_t;
    typedef logic [ROW_W-1:0]  row_idx_t;
    typedef logic [BANK_W-1:0] bank_idx_t;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FILL  = 2'd1;
    localparam state_t ST_STALL = 2'd2;

    // Bank-local word address of (segment, row); at most 95, fits 7 bits.
    function automatic logic [ADDR_W-1:0] make_addr(input seg_idx_t seg, input row_idx_t row);
        logic [ADDR_W-1:0] base;
        base = ADDR_W'(seg) * ADDR_W'(SEG_LEN);
        return base + ADDR_W'(row);
    endfunction

endpackage

// File: rtl/ref_bank_wr_ptr.sv
// Write pointer chain (word -> bank -> segment) for the bank ring, with segment/ring wrap strobes.
module ref_bank_wr_ptr
    import ref_bank_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                adv,
    output logic [ROW_W-1:0]    word,
    output logic [BANK_W-1:0]   bank,
    output logic [SEG_W-1:0]    seg,
    output logic [SEG_W-1:0]    next_seg,
    output logic                seg_done,
    output logic                ring_done
);

    row_idx_t  word_reg, word_next;
    bank_idx_t bank_reg, bank_next;
    seg_idx_t  seg_reg,  seg_next;

    assign seg_done  = adv & (word_reg == row_idx_t'(SEG_LEN - 1));
    assign ring_done = seg_done & (bank_reg == bank_idx_t'(NUM_BANK - 1));

    always_comb begin
        word_next = word_reg;
        bank_next = bank_reg;
        seg_next  = seg_reg;
        if (adv) begin
            if (seg_done) begin
                word_next = '0;
                bank_next = ring_done ? '0 : bank_reg + bank_idx_t'(1);
                if (ring_done) begin
                    seg_next = (seg_reg == seg_idx_t'(NUM_SEG - 1)) ? '0 : seg_reg + seg_idx_t'(1);
                end
            end else begin
                word_next = word_reg + row_idx_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_reg <= '0;
            bank_reg <= '0;
            seg_reg  <= '0;
        end else begin
            word_reg <= word_next;
            bank_reg <= bank_next;
            seg_reg  <= seg_next;
        end
    end

    assign word     = word_reg;
    assign bank     = bank_reg;
    assign seg      = seg_reg;
    assign next_seg = seg_next;

endmodule

// File: rtl/ref_bank_sched.sv
// Write/read scheduler for the ME reference bank ring: round-robin fill, read gating, segment release.
// Optional stall statistics port stall_cnt when REF_BANK_SCHED_STATS_EN is defined.
module ref_bank_sched
    import ref_bank_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WORD_W-1:0]   ref_data,
    input  logic                ref_valid,
    output logic                ref_ready,
    output logic [WORD_W-1:0]   bank_wdata,
    output logic [NUM_BANK-1:0] bank_sel_n,
    output logic [ADDR_W-1:0]   wr_addr,
    input  logic                rd_req,
    input  logic [SEG_W-1:0]    rd_seg,
    input  logic [ROW_W-1:0]    rd_row,
    output logic                rd_gnt,
    output logic                rd_en_n,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_vld,
    input  logic                seg_release,
    input  logic [SEG_W-1:0]    rel_seg,
    output logic [NUM_SEG-1:0]  seg_valid
`ifdef REF_BANK_SCHED_STATS_EN
    ,
    output logic [15:0]         stall_cnt
`endif
);

    state_t              state_reg, state_next;
    logic [NUM_SEG-1:0]  seg_valid_reg, seg_valid_next;
    logic                rd_vld_reg;
    logic                accept;
    logic                stall_hit;
    row_idx_t            cur_word;
    bank_idx_t           cur_bank;
    seg_idx_t            cur_seg, next_seg;
    logic                seg_done, ring_done;
    logic                unused_seg_done;

    ref_bank_wr_ptr u_wr_ptr (
        .clk       (clk),
        .rst_n     (rst_n),
        .adv       (accept),
        .word      (cur_word),
        .bank      (cur_bank),
        .seg       (cur_seg),
        .next_seg  (next_seg),
        .seg_done  (seg_done),
        .ring_done (ring_done)
    );

    assign unused_seg_done = seg_done;

    // Gated by rst_n so the fetch side sees "not ready" for the whole reset pulse.
    assign ref_ready  = rst_n & (state_reg != ST_STALL) & ~seg_valid_reg[cur_seg];
    assign accept     = ref_valid & ref_ready;
    assign bank_wdata = ref_data;
    assign wr_addr    = make_addr(cur_seg, cur_word);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANK; gi++) begin : g_bank
            assign bank_sel_n[gi] = ~(accept & (cur_bank == bank_idx_t'(gi)));
        end

        // Set on ring completion takes priority over a same-cycle release.
        for (gi = 0; gi < NUM_SEG; gi++) begin : g_seg
            logic set_hit;
            logic clr_hit;
            assign set_hit = ring_done & (cur_seg == seg_idx_t'(gi));
            assign clr_hit = seg_release & (rel_seg == seg_idx_t'(gi));
            assign seg_valid_next[gi] = set_hit | (seg_valid_reg[gi] & ~clr_hit);
        end
    endgenerate

    assign stall_hit = ring_done & seg_valid_next[next_seg];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (ref_valid) state_next = ST_FILL;
            ST_FILL:  if (stall_hit) state_next = ST_STALL;
            ST_STALL: if (!seg_valid_reg[cur_seg]) state_next = ST_FILL;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            seg_valid_reg <= '0;
            rd_vld_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            seg_valid_reg <= seg_valid_next;
            rd_vld_reg    <= rd_gnt;
        end
    end

    // Reads only ever target completed segments, so they never collide with the writer.
    assign rd_gnt    = rd_req & seg_valid_reg[rd_seg] & (rd_row < row_idx_t'(SEG_LEN));
    assign rd_en_n   = ~rd_gnt;
    assign rd_addr   = make_addr(rd_seg, rd_row);
    assign rd_vld    = rd_vld_reg;
    assign seg_valid = seg_valid_reg;

`ifdef REF_BANK_SCHED_STATS_EN
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (ref_valid && !ref_ready && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_ref_bank_sched.sv
// Directed self-checking bench for ref_bank_sched (stall_cnt checked when REF_BANK_SCHED_STATS_EN is defined).
`timescale 1ns/1ps
module tb_ref_bank_sched;
    import ref_bank_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [WORD_W-1:0]   ref_data;
    logic                ref_valid;
    logic                ref_ready;
    logic [WORD_W-1:0]   bank_wdata;
    logic [NUM_BANK-1:0] bank_sel_n;
    logic [ADDR_W-1:0]   wr_addr;
    logic                rd_req;
    logic [SEG_W-1:0]    rd_seg;
    logic [ROW_W-1:0]    rd_row;
    logic                rd_gnt;
    logic                rd_en_n;
    logic [ADDR_W-1:0]   rd_addr;
    logic                rd_vld;
    logic                seg_release;
    logic [SEG_W-1:0]    rel_seg;
    logic [NUM_SEG-1:0]  seg_valid;
`ifdef REF_BANK_SCHED_STATS_EN
    logic [15:0]         stall_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int wn    = 0;
    int lat;

    ref_bank_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ref_data    (ref_data),
        .ref_valid   (ref_valid),
        .ref_ready   (ref_ready),
        .bank_wdata  (bank_wdata),
        .bank_sel_n  (bank_sel_n),
        .wr_addr     (wr_addr),
        .rd_req      (rd_req),
        .rd_seg      (rd_seg),
        .rd_row      (rd_row),
        .rd_gnt      (rd_gnt),
        .rd_en_n     (rd_en_n),
        .rd_addr     (rd_addr),
        .rd_vld      (rd_vld),
        .seg_release (seg_release),
        .rel_seg     (rel_seg),
        .seg_valid   (seg_valid)
`ifdef REF_BANK_SCHED_STATS_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
        if (obs === exp) $display("ok   %s obs=%0h", tag, obs);
    endtask

    // Streams n words; expected bank/address follow the round-robin fill order from word count wn.
    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            logic [63:0] d;
            logic [3:0]  sel;
            int          b;
            int          a;
            d = {$urandom, $urandom};
            ref_data  = d;
            ref_valid = 1'b1;
            b   = (wn / 24) % 4;
            a   = ((wn / 96) % 4) * 24 + (wn % 24);
            sel = ~(4'(1) << b);
            #1;
            chk($sformatf("wr%0d", wn), {4'b0, ref_ready, bank_sel_n, wr_addr, bank_wdata},
                {4'b0, 1'b1, sel, 7'(a), d});
            @(posedge clk);
            wn++;
            @(negedge clk);
        end
        ref_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ref_valid = 1'b1; ref_data = '0;
        rd_req = 1'b0; rd_seg = '0; rd_row = '0;
        seg_release = 1'b0; rel_seg = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready",  80'(ref_ready),  80'(1'b0));
        chk("rst_sel",    80'(bank_sel_n), 80'(4'hF));
        chk("rst_rden",   80'(rd_en_n),    80'(1'b1));
        chk("rst_waddr",  80'(wr_addr),    80'(7'd0));
        chk("rst_segv",   80'(seg_valid),  80'(4'h0));
        chk("rst_rdvld",  80'(rd_vld),     80'(1'b0));
        @(negedge clk);
        ref_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("idle_state", 80'(dut.state_reg), 80'(ST_IDLE));
        @(negedge clk);

        // 1: first full ring pass completes segment 0
        push(96);
        chk("t1_segv", 80'(seg_valid), 80'(4'b0001));

        // 2: read gating before and at row boundary
        rd_req = 1'b1; rd_seg = 2'd1; rd_row = 5'd5; #1;
        chk("t2_deny_gnt", 80'(rd_gnt),  80'(1'b0));
        chk("t2_deny_en",  80'(rd_en_n), 80'(1'b1));
        @(posedge clk); @(negedge clk);
        chk("t2_deny_vld", 80'(rd_vld), 80'(1'b0));
        rd_seg = 2'd0; rd_row = 5'd23; #1;
        chk("t2_row23", 80'({rd_gnt, rd_addr}), 80'({1'b1, 7'd23}));
        rd_row = 5'd24; #1;
        chk("t2_row24", 80'(rd_gnt), 80'(1'b0));
        rd_req = 1'b0;

        // 5: releasing an invalid segment changes nothing
        seg_release = 1'b1; rel_seg = 2'd3;
        @(posedge clk); @(negedge clk);
        seg_release = 1'b0; #1;
        chk("t5_segv",  80'(seg_valid), 80'(4'b0001));
        chk("t5_ready", 80'(ref_ready), 80'(1'b1));
        push(96);
        chk("t2_segv", 80'(seg_valid), 80'(4'b0011));
        rd_req = 1'b1; rd_seg = 2'd1; rd_row = 5'd5; #1;
        chk("t2_gnt",  80'({rd_gnt, rd_en_n, rd_addr}), 80'({1'b1, 1'b0, 7'd29}));
        @(posedge clk); #1;
        chk("t2_vld",  80'(rd_vld), 80'(1'b1));
        rd_req = 1'b0;
        @(posedge clk); #1;
        chk("t2_vld_off", 80'(rd_vld), 80'(1'b0));
        @(negedge clk);

        // 3: fill all segments, writer must stall
        push(192);
        chk("t3_segv", 80'(seg_valid), 80'(4'b1111));
        ref_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            #1;
            chk($sformatf("t3_hold%0d", i), 80'({ref_ready, bank_sel_n}), 80'({1'b0, 4'hF}));
            @(posedge clk); @(negedge clk);
        end
        chk("t3_state", 80'(dut.state_reg), 80'(ST_STALL));
`ifdef REF_BANK_SCHED_STATS_EN
        chk("t6_stall_cnt", 80'(stall_cnt), 80'(16'd50));
`endif
        seg_release = 1'b1; rel_seg = 2'd0;
        @(posedge clk); @(negedge clk);
        seg_release = 1'b0; #1;
        chk("t3_rel_segv", 80'(seg_valid), 80'(4'b1110));
        lat = 1;
        while (!ref_ready && lat < 4) begin
            @(posedge clk); @(negedge clk); #1;
            lat++;
        end
        chk("t3_resume", 80'(ref_ready && (lat <= 2)), 80'(1'b1));
        push(58);

        // 4: async reset mid-segment (bank 2, w=10)
        rd_req = 1'b1; rd_seg = 2'd1; rd_row = 5'd0;
        @(posedge clk); #1;
        chk("t4_pre", 80'({rd_vld, wr_addr}), 80'({1'b1, 7'd10}));
        rst_n = 1'b0; ref_valid = 1'b1; #1;
        chk("t4_ready", 80'(ref_ready),  80'(1'b0));
        chk("t4_sel",   80'(bank_sel_n), 80'(4'hF));
        chk("t4_rd",    80'({rd_gnt, rd_en_n}), 80'({1'b0, 1'b1}));
        chk("t4_waddr", 80'(wr_addr),    80'(7'd0));
        chk("t4_segv",  80'(seg_valid),  80'(4'h0));
        chk("t4_rdvld", 80'(rd_vld),     80'(1'b0));
        @(negedge clk); @(negedge clk);
        ref_valid = 1'b0; rd_req = 1'b0; rst_n = 1'b1;
        wn = 0;
        @(negedge clk);
        push(24);
        chk("t4_segv_after", 80'(seg_valid), 80'(4'h0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
